spi_reg_slave: RTL and testbench

SPI responder (slave end) fronting an 8-bit register file, for use on the far side of the existing SPI master. It oversamples SCLK/CS/MOSI in the system clock domain, decodes a command byte followed by data bytes with burst auto-increment, and serves reads on MISO. Supports all four CPOL/CPHA modes, selected by static inputs that must match the master's setting.

---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sync_edge.sv | 26 ++
 rtl/spi_reg_slave.sv | 114 +++++++++++
 tb/tb_spi_reg_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type, command layout and SPI mode helper for spi_reg_slave.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  localparam int RW_BIT = 7;
  function automatic logic sample_on_leading(input logic [1:0] mode);
    return (mode == 2'b00) || (mode == 2'b10);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulse detection on the synchronized level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic              prev;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sr   <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sr   <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  assign q    = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: oversampled SPI responder over an 8-bit register file with burst auto-increment.
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int         ADDR_W      = 3,
  parameter logic [7:0] STATUS_BYTE = 8'h5A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] lcl_addr,
  output logic [7:0]        lcl_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);
  localparam int NREG = 2**ADDR_W;
  logic                   sclk_q, sclk_rise, sclk_fall;
  logic                   cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   mosi_q;
  logic                   sclk_edge, lead, trail, sample, shift;
  logic [7:0]             regs [NREG];
  logic [7:0]             rx, tx, rx_byte;
  logic [2:0]             cnt;
  logic [ADDR_W-1:0]      ptr, ptr_nx, cmd_addr;
  logic                   rw;
  state_t                 state;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) mosi_sr <= '0;
    else mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
  assign mosi_q = mosi_sr[SYNC_STAGES-1];

  // Leading edge moves SCLK away from its idle level, so the new level differs from cpol.
  assign sclk_edge = sclk_rise | sclk_fall;
  assign lead      = sclk_edge & (sclk_q ^ cpol);
  assign trail     = sclk_edge & ~(sclk_q ^ cpol);
  assign sample    = sample_on_leading({cpol, cpha}) ? lead : trail;
  assign shift     = sample_on_leading({cpol, cpha}) ? trail : lead;
  assign rx_byte   = {rx[6:0], mosi_q};
  assign ptr_nx    = ptr + 1'b1;
  assign cmd_addr  = rx_byte[ADDR_W-1:0];
  assign lcl_rdata = regs[lcl_addr];

  // Writes commit one clk after wr_strobe so local reads see the old value during the strobe.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (wr_strobe) regs[wr_addr] <= wr_data;
      if (state != IDLE && (cs_rise || cs_q)) begin
        state   <= IDLE;
        cnt     <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (state == IDLE) begin
        if (cs_fall) begin
          state   <= CMD;
          cnt     <= '0;
          tx      <= STATUS_BYTE;
          miso    <= STATUS_BYTE[7];
          miso_oe <= 1'b1;
        end
      end else if (sample) begin
        rx  <= rx_byte;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          if (state == CMD) begin
            state <= DATA;
            rw    <= rx_byte[RW_BIT];
            ptr   <= cmd_addr;
            if (rx_byte[RW_BIT]) tx <= regs[cmd_addr];
          end else if (rw) begin
            ptr <= ptr_nx;
            tx  <= regs[ptr_nx];
          end else begin
            wr_strobe <= 1'b1;
            wr_addr   <= ptr;
            wr_data   <= rx_byte;
            ptr       <= ptr_nx;
          end
        end
      end else if (shift) begin
        miso <= tx[~cnt];
      end
    end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: directed SPI master stimulus with hand-computed expectations for spi_reg_slave.
module tb_spi_reg_slave;
  logic       clk = 1'b0, reset = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [2:0] lcl_addr = 3'd0;
  logic       miso, miso_oe, wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] lcl_rdata, wr_data;
  int         tests = 0, fails = 0, nstb = 0;
  logic [2:0] last_a = 3'd0;
  logic [7:0] last_d = 8'd0, during_val = 8'd0, after_val = 8'd0;
  logic       prev_stb = 1'b0;

  spi_reg_slave #(.ADDR_W(3), .STATUS_BYTE(8'h5A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .lcl_addr(lcl_addr), .lcl_rdata(lcl_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (wr_strobe) begin
      nstb   <= nstb + 1;
      last_a <= wr_addr;
      last_d <= wr_data;
    end

  always @(negedge clk) begin
    if (prev_stb) after_val <= lcl_rdata;
    if (wr_strobe) during_val <= lcl_rdata;
    prev_stb <= wr_strobe;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    clks(8);
  endtask

  task automatic cs_on();
    cs_n = 1'b0;
    clks(8);
  endtask

  task automatic cs_off();
    clks(8);
    cs_n = 1'b1;
    clks(16);
  endtask

  task automatic xfer_bits(input logic [7:0] t, input int n, output logic [7:0] r);
    r = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cpha) begin
        mosi = t[i];
        clks(8);
        sclk = ~cpol;
        r[i] = miso;
        clks(8);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = t[i];
        clks(8);
        sclk = cpol;
        r[i] = miso;
        clks(8);
      end
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    lcl_addr = a;
    #1 v = lcl_rdata;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    clks(2);
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL reset_miso: got %b want 0", miso); end
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
    tests++; if (wr_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
    tests++; if ({wr_addr, wr_data} !== 11'd0) begin fails++; $display("FAIL reset_wr: got %h/%h want 0/00", wr_addr, wr_data); end
    rd(3'd5, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_reg5: got %h want 00", v); end
    reset = 1'b1;
    clks(4);
  endtask

  task automatic test_mode0_write();
    logic [7:0] r, v;
    int s0;
    set_mode(1'b0, 1'b0);
    s0 = nstb;
    cs_on();
    xfer_bits(8'h03, 8, r);
    tests++; if (r !== 8'h5A) begin fails++; $display("FAIL m0_status: got %h want 5a", r); end
    tests++; if (miso_oe !== 1'b1) begin fails++; $display("FAIL m0_oe: got %b want 1", miso_oe); end
    xfer_bits(8'hC3, 8, r);
    cs_off();
    tests++; if (nstb - s0 !== 1) begin fails++; $display("FAIL m0_strobes: got %0d want 1", nstb - s0); end
    tests++; if (last_a !== 3'd3) begin fails++; $display("FAIL m0_wr_addr: got %0d want 3", last_a); end
    tests++; if (last_d !== 8'hC3) begin fails++; $display("FAIL m0_wr_data: got %h want c3", last_d); end
    rd(3'd3, v);
    tests++; if (v !== 8'hC3) begin fails++; $display("FAIL m0_reg3: got %h want c3", v); end
  endtask

  task automatic test_burst_mode3();
    logic [7:0] r, v;
    int s0;
    set_mode(1'b1, 1'b1);
    s0 = nstb;
    cs_on();
    xfer_bits(8'h06, 8, r);
    xfer_bits(8'h11, 8, r);
    xfer_bits(8'h22, 8, r);
    xfer_bits(8'h33, 8, r);
    cs_off();
    tests++; if (nstb - s0 !== 3) begin fails++; $display("FAIL m3_strobes: got %0d want 3", nstb - s0); end
    rd(3'd6, v);
    tests++; if (v !== 8'h11) begin fails++; $display("FAIL m3_reg6: got %h want 11", v); end
    rd(3'd7, v);
    tests++; if (v !== 8'h22) begin fails++; $display("FAIL m3_reg7: got %h want 22", v); end
    rd(3'd0, v);
    tests++; if (v !== 8'h33) begin fails++; $display("FAIL m3_reg0_wrap: got %h want 33", v); end
  endtask

  task automatic test_read_modes();
    logic [7:0] r0, r1, r2, r;
    for (int m = 0; m < 2; m++) begin
      set_mode(m == 1, m == 0);
      cs_on();
      xfer_bits(8'h07, 8, r);
      xfer_bits(8'hAB, 8, r);
      xfer_bits(8'hCD, 8, r);
      cs_off();
      cs_on();
      xfer_bits(8'h87, 8, r0);
      xfer_bits(8'h00, 8, r1);
      xfer_bits(8'h00, 8, r2);
      cs_off();
      tests++; if (r0 !== 8'h5A) begin fails++; $display("FAIL rd_mode%0d_status: got %h want 5a", m + 1, r0); end
      tests++; if (r1 !== 8'hAB) begin fails++; $display("FAIL rd_mode%0d_byte1: got %h want ab", m + 1, r1); end
      tests++; if (r2 !== 8'hCD) begin fails++; $display("FAIL rd_mode%0d_byte2: got %h want cd", m + 1, r2); end
    end
  endtask

  task automatic test_partial();
    logic [7:0] r, v;
    int s0, k;
    set_mode(1'b0, 1'b0);
    s0 = nstb;
    cs_on();
    xfer_bits(8'h02, 8, r);
    xfer_bits(8'hFF, 5, r);
    cs_n = 1'b1;
    for (k = 0; k < 8; k++) begin
      if (!miso_oe) break;
      @(negedge clk);
    end
    tests++; if (k > 3) begin fails++; $display("FAIL partial_oe_delay: got %0d clks want <=3", k); end
    clks(16);
    tests++; if (nstb - s0 !== 0) begin fails++; $display("FAIL partial_strobes: got %0d want 0", nstb - s0); end
    rd(3'd2, v);
    tests++; if (v !== 8'h00) begin fails++; $display("FAIL partial_reg2: got %h want 00", v); end
    cs_on();
    xfer_bits(8'h02, 8, r);
    xfer_bits(8'h77, 8, r);
    cs_off();
    rd(3'd2, v);
    tests++; if (v !== 8'h77) begin fails++; $display("FAIL partial_refill: got %h want 77", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r, v;
    int nz;
    set_mode(1'b0, 1'b0);
    cs_on();
    xfer_bits(8'h01, 8, r);
    xfer_bits(8'h55, 8, r);
    xfer_bits(8'h66, 8, r);
    clks(4);
    reset = 1'b0;
    #1;
    tests++; if (miso_oe !== 1'b0) begin fails++; $display("FAIL rstmid_oe: got %b want 0", miso_oe); end
    tests++; if (miso !== 1'b0) begin fails++; $display("FAIL rstmid_miso: got %b want 0", miso); end
    nz = 0;
    for (int a = 0; a < 8; a++) begin
      rd(a[2:0], v);
      if (v !== 8'h00) nz++;
    end
    tests++; if (nz !== 0) begin fails++; $display("FAIL rstmid_regs: got %0d nonzero want 0", nz); end
    cs_n = 1'b1;
    clks(2);
    reset = 1'b1;
    clks(8);
    cs_on();
    xfer_bits(8'h05, 8, r);
    xfer_bits(8'h5E, 8, r);
    cs_off();
    rd(3'd5, v);
    tests++; if (v !== 8'h5E) begin fails++; $display("FAIL rstmid_after: got %h want 5e", v); end
  endtask

  task automatic test_coincident();
    logic [7:0] r;
    set_mode(1'b0, 1'b0);
    cs_on();
    xfer_bits(8'h04, 8, r);
    xfer_bits(8'h44, 8, r);
    cs_off();
    lcl_addr = 3'd4;
    cs_on();
    xfer_bits(8'h04, 8, r);
    xfer_bits(8'h9E, 8, r);
    cs_off();
    tests++; if (during_val !== 8'h44) begin fails++; $display("FAIL coinc_during: got %h want 44", during_val); end
    tests++; if (after_val !== 8'h9E) begin fails++; $display("FAIL coinc_after: got %h want 9e", after_val); end
  endtask

  initial begin
    test_reset();
    test_mode0_write();
    test_burst_mode3();
    test_read_modes();
    test_partial();
    test_reset_mid();
    test_coincident();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
